// File: rtl/dbg_uart_pkg.sv
// Shared types and constants for the debug UART receive path.
// Imported by the receiver top level and its FIFO.
package dbg_uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    // Pointer width for a power-of-two FIFO; the occupancy count is one bit wider.
    function automatic int fifo_ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dbg_uart_rx_fifo.sv
// First-word fall-through FIFO: head entry is always presented on data_o.
// A push into a full FIFO is dropped (with an overrun pulse) unless a pop frees a slot that cycle.
module dbg_uart_rx_fifo
    import dbg_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         overrun_o
);

    localparam int PW = fifo_ptr_w(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_overrun;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PW+1)'(DEPTH));
    assign w_pop   = pop_i && !w_empty;
    assign w_push  = push_i && (!w_full || w_pop);

    // Pointers are PW bits wide, so wrap-around is the natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= push_i && w_full && !w_pop;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

    assign valid_o   = !w_empty;
    assign data_o    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign overrun_o = r_overrun;

endmodule

// File: rtl/dbg_uart_rx.sv
// Debug UART receiver: 8N1 deserialiser with mid-bit sampling feeding a small FWFT FIFO.
// Handshake: a byte transfers on any cycle where valid_o && ready_i; valid_o never depends on ready_i.
module dbg_uart_rx
    import dbg_uart_pkg::*;
#(
    parameter int CLK_DIV    = 87,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o,
    output rx_state_e            dbg_state_o
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic [1:0]           r_sync;
    rx_state_e            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_frame_err;

    rx_state_e            w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [2:0]           w_bit_idx_nxt;
    logic [DATA_BITS-1:0] w_shreg_nxt;
    logic                 w_frame_err;
    logic                 w_push;
    logic                 w_rx_s;
    logic                 w_tick;

    assign w_rx_s = r_sync[1];
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync      <= 2'b11;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], rx_i};
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shreg     <= w_shreg_nxt;
            r_frame_err <= w_frame_err;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shreg_nxt   = r_shreg;
        w_frame_err   = 1'b0;
        w_push        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = HALF_LOAD;
                end
            end
            START: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!w_rx_s) begin
                    w_state_nxt   = DATA;
                    w_cnt_nxt     = BIT_LOAD;
                    w_bit_idx_nxt = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_shreg_nxt = {w_rx_s, r_shreg[DATA_BITS-1:1]};
                    w_cnt_nxt   = BIT_LOAD;
                    if (r_bit_idx == LAST_BIT) w_state_nxt = STOP;
                    else                       w_bit_idx_nxt = r_bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_rx_s) begin
                    // Returning to IDLE mid-stop-bit lets the next start edge be caught early.
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_frame_err = 1'b1;
                    w_state_nxt = BREAK;
                end
            end
            BREAK: begin
                if (w_rx_s) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    dbg_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_BITS)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (w_push),
        .data_i    (r_shreg_push_data()),
        .pop_i     (ready_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .overrun_o (overrun_o)
    );

    // The stop tick pushes the fully assembled byte held in the shift register.
    function automatic logic [DATA_BITS-1:0] r_shreg_push_data();
        return r_shreg;
    endfunction

    assign frame_err_o = r_frame_err;
    assign busy_o      = (r_state != IDLE);
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dbg_uart_rx.sv
// Directed bench for dbg_uart_rx with CLK_DIV=16, FIFO_DEPTH=4.
module tb_dbg_uart_rx;
    import dbg_uart_pkg::*;

    localparam int DIV = 16;

    logic       clk_i;
    logic       rst_ni;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;
    rx_state_e  dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int n_vcyc   = 0;
    int n_double = 0;
    logic prev_ferr = 1'b0;
    logic prev_ovr  = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    dbg_uart_rx #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // monitor: record transfers and pulse activity
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (valid_o) n_vcyc++;
            if (frame_err_o) n_ferr++;
            if (overrun_o) n_ovr++;
            if ((frame_err_o && prev_ferr) || (overrun_o && prev_ovr)) n_double++;
        end
        prev_ferr = frame_err_o;
        prev_ovr  = overrun_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // driver
    task automatic drive_bit(input logic v);
        @(negedge clk_i);
        rx_i = v;
        repeat (DIV - 1) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // scoreboard: compare recorded stream against expected queue, then clear both
    task automatic check_stream(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    int ferr0;
    int ovr0;
    int vcyc0;

    initial begin
        rx_i    = 1'b1;
        ready_i = 1'b1;
        rst_ni  = 1'b0;
        wait_cycles(4);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ferr", 32'(frame_err_o), 32'd0);
        check("rst_ovr", 32'(overrun_o), 32'd0);
        rst_ni = 1'b1;
        wait_cycles(4);

        // 1: single frame 0xA5, consumer always ready
        vcyc0 = n_vcyc; ferr0 = n_ferr; ovr0 = n_ovr;
        exp_q.push_back(8'hA5);
        fork
            send_byte(8'hA5, 1'b1);
            begin
                wait_cycles(40);
                check("s1_busy_mid", 32'(busy_o), 32'd1);
            end
        join
        check("s1_busy_end", 32'(busy_o), 32'd0);
        wait_cycles(4);
        check("s1_valid_cycles", 32'(n_vcyc - vcyc0), 32'd1);
        check("s1_ferr", 32'(n_ferr - ferr0), 32'd0);
        check("s1_ovr", 32'(n_ovr - ovr0), 32'd0);
        check_stream("s1");

        // 2: short glitch rejected by START
        vcyc0 = n_vcyc; ferr0 = n_ferr;
        @(negedge clk_i);
        rx_i = 1'b0;
        wait_cycles(4);
        check("s2_busy_glitch", 32'(busy_o), 32'd1);
        rx_i = 1'b1;
        wait_cycles(8);
        check("s2_busy_after", 32'(busy_o), 32'd0);
        check("s2_valid", 32'(n_vcyc - vcyc0), 32'd0);
        check("s2_ferr", 32'(n_ferr - ferr0), 32'd0);
        wait_cycles(10);

        // 3: bad stop bit then held break, then a good frame
        ferr0 = n_ferr;
        send_byte(8'h3C, 1'b0);
        wait_cycles(40);
        check("s3_state_break", 32'(dbg_state_o), 32'(BREAK));
        rx_i = 1'b1;
        wait_cycles(20);
        check("s3_ferr_once", 32'(n_ferr - ferr0), 32'd1);
        check_stream("s3_nodata");
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        wait_cycles(4);
        check_stream("s3_good");

        // 4: fill with consumer stalled, fifth byte overruns
        ready_i = 1'b0;
        ovr0 = n_ovr;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        wait_cycles(4);
        check("s4_ovr", 32'(n_ovr - ovr0), 32'd1);
        check("s4_valid", 32'(valid_o), 32'd1);
        check("s4_head", 32'(data_o), 32'h01);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        ready_i = 1'b1;
        wait_cycles(8);
        check("s4_drained", 32'(valid_o), 32'd0);
        check_stream("s4");

        // 5: back-to-back frames with no idle gap
        ferr0 = n_ferr; ovr0 = n_ovr;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_cycles(4);
        check("s5_ferr", 32'(n_ferr - ferr0), 32'd0);
        check("s5_ovr", 32'(n_ovr - ovr0), 32'd0);
        check_stream("s5");

        // 6: reset mid-frame with two bytes buffered
        ready_i = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(negedge clk_i);
        rx_i = 1'b1;
        wait_cycles(8);
        check("s6_pre_valid", 32'(valid_o), 32'd1);
        check("s6_pre_busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("s6_rst_valid", 32'(valid_o), 32'd0);
        check("s6_rst_data", 32'(data_o), 32'h0);
        check("s6_rst_busy", 32'(busy_o), 32'd0);
        check("s6_rst_ferr", 32'(frame_err_o), 32'd0);
        check("s6_rst_ovr", 32'(overrun_o), 32'd0);
        got_q.delete();
        wait_cycles(4);
        rst_ni = 1'b1;
        wait_cycles(4);
        ready_i = 1'b1;
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        wait_cycles(4);
        check_stream("s6");

        check("pulse_width", 32'(n_double), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
